// File: rtl/amm_mem_responder.sv
`timescale 1ns/1ps
// Avalon-MM burst memory responder: byte-lane-enabled burst writes, fixed-latency
// burst reads from an internal word memory, optional pseudo-random waitrequest.
module amm_mem_responder #(
    parameter int ADDR_W      = 31,
    parameter int DATA_W      = 128,
    parameter int BURST_W     = 11,
    parameter int MEM_ADDR_W  = 10,
    parameter int WAIT_INJECT = 0
) (
    input  logic                  clk_mem_i,
    input  logic                  rst_mem_n_i,
    input  logic [ADDR_W-1:0]     mem_address_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic [DATA_W-1:0]     mem_writedata_i,
    input  logic [BURST_W-1:0]    mem_burstcount_i,
    input  logic [DATA_W/8-1:0]   mem_byteenable_i,
    output logic                  mem_waitrequest_o,
    output logic                  mem_readdatavalid_o,
    output logic [DATA_W-1:0]     mem_readdata_o
);

    localparam int BYTES = DATA_W / 8;
    localparam int DEPTH = 2 ** MEM_ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [MEM_ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [MEM_ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [BURST_W-1:0]     wr_left_q, wr_left_d;
    logic [BURST_W-1:0]     rd_left_q, rd_left_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic                   waitreq_q, waitreq_d;
    logic                   rvalid_q, rvalid_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;

    logic                   accept;
    logic                   inject_d;
    logic                   mem_we;
    logic [MEM_ADDR_W-1:0]  mem_waddr;
    logic [DATA_W-1:0]      rd_word;

    always_comb begin
        lfsr_d    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        inject_d  = (WAIT_INJECT != 0) ? (lfsr_d[0] & lfsr_d[1]) : 1'b0;
        accept    = rst_mem_n_i & (mem_read_i | mem_write_i) & ~waitreq_q;

        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        wr_left_d = wr_left_q;
        rd_left_d = rd_left_q;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_q;
        mem_we    = 1'b0;
        mem_waddr = wr_ptr_q;

        case (state_q)
            ST_IDLE: begin
                // Zero-length commands are consumed without touching memory or state.
                if (accept && (mem_burstcount_i != '0)) begin
                    if (mem_write_i) begin
                        mem_we    = 1'b1;
                        mem_waddr = mem_address_i[MEM_ADDR_W-1:0];
                        if (mem_burstcount_i > BURST_W'(1)) begin
                            state_d   = ST_WRITE;
                            wr_ptr_d  = mem_address_i[MEM_ADDR_W-1:0] + MEM_ADDR_W'(1);
                            wr_left_d = mem_burstcount_i - BURST_W'(1);
                        end
                    end else begin
                        state_d   = ST_READ;
                        rd_ptr_d  = mem_address_i[MEM_ADDR_W-1:0];
                        rd_left_d = mem_burstcount_i;
                    end
                end
            end
            ST_WRITE: begin
                if (accept && mem_write_i) begin
                    mem_we    = 1'b1;
                    wr_ptr_d  = wr_ptr_q + MEM_ADDR_W'(1);
                    wr_left_d = wr_left_q - BURST_W'(1);
                    if (wr_left_q == BURST_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_READ: begin
                if (rd_left_q != '0) begin
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_word;
                    rd_ptr_d  = rd_ptr_q + MEM_ADDR_W'(1);
                    rd_left_d = rd_left_q - BURST_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        waitreq_d = (state_d == ST_READ) ? 1'b1 : inject_d;
    end

    always_ff @(posedge clk_mem_i or negedge rst_mem_n_i) begin
        if (!rst_mem_n_i) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            wr_left_q <= '0;
            rd_left_q <= '0;
            lfsr_q    <= 16'hACE1;
            waitreq_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_left_q <= wr_left_d;
            rd_left_q <= rd_left_d;
            lfsr_q    <= lfsr_d;
            waitreq_q <= waitreq_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    // One narrow memory per byte lane so disabled lanes are simply not written.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            always_ff @(posedge clk_mem_i) begin
                if (mem_we && mem_byteenable_i[gi]) begin
                    lane_mem[mem_waddr] <= mem_writedata_i[gi*8 +: 8];
                end
            end

            assign rd_word[gi*8 +: 8] = lane_mem[rd_ptr_q];
        end

        if (ADDR_W > MEM_ADDR_W) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^mem_address_i[ADDR_W-1:MEM_ADDR_W];
        end
    endgenerate

    assign mem_waitrequest_o   = waitreq_q;
    assign mem_readdatavalid_o = rvalid_q;
    assign mem_readdata_o      = rdata_q;

endmodule

// File: tb/tb_amm_mem_responder.sv
`timescale 1ns/1ps
// Scoreboard bench for amm_mem_responder: directed burst, wrap, byte-enable,
// stall, reset-abort cases followed by random bursts with waitrequest injection.
module tb_amm_mem_responder;

    localparam int ADDR_W     = 31;
    localparam int DATA_W     = 128;
    localparam int BURST_W    = 11;
    localparam int MEM_ADDR_W = 10;
    localparam int DEPTH      = 1 << MEM_ADDR_W;
    localparam int BYTES      = DATA_W / 8;

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b0;
    logic [ADDR_W-1:0]    mem_address_i    = '0;
    logic                 mem_read_i       = 1'b0;
    logic                 mem_write_i      = 1'b0;
    logic [DATA_W-1:0]    mem_writedata_i  = '0;
    logic [BURST_W-1:0]   mem_burstcount_i = '0;
    logic [BYTES-1:0]     mem_byteenable_i = '0;
    logic                 mem_waitrequest_o;
    logic                 mem_readdatavalid_o;
    logic [DATA_W-1:0]    mem_readdata_o;

    always #5 clk = ~clk;

    amm_mem_responder #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .BURST_W     (BURST_W),
        .MEM_ADDR_W  (MEM_ADDR_W),
        .WAIT_INJECT (1)
    ) dut (
        .clk_mem_i           (clk),
        .rst_mem_n_i         (rst_n),
        .mem_address_i       (mem_address_i),
        .mem_read_i          (mem_read_i),
        .mem_write_i         (mem_write_i),
        .mem_writedata_i     (mem_writedata_i),
        .mem_burstcount_i    (mem_burstcount_i),
        .mem_byteenable_i    (mem_byteenable_i),
        .mem_waitrequest_o   (mem_waitrequest_o),
        .mem_readdatavalid_o (mem_readdatavalid_o),
        .mem_readdata_o      (mem_readdata_o)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] wbuf [DEPTH];
    logic [BYTES-1:0]  bebuf [DEPTH];
    logic [DATA_W-1:0] last_exp = '0;
    int                cyc      = 0;
    int                n_valid  = 0;
    int                n_checks = 0;
    int                n_fail   = 0;

    // cyc = number of rising edges seen; a value sampled on the falling edge
    // with cyc == X is what the master sees at rising edge X+1.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] obs,
                            input logic [DATA_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                                input logic [DATA_W-1:0] d,
                                                input logic [BYTES-1:0] be);
        logic [DATA_W-1:0] r;
        r = old;
        for (int b = 0; b < BYTES; b++) begin
            if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
        end
        return r;
    endfunction

    function automatic int widx(input logic [ADDR_W-1:0] a, input int k);
        return (int'(a[MEM_ADDR_W-1:0]) + k) % DEPTH;
    endfunction

    // Read-data monitor: every valid beat must match the head of the scoreboard
    // in data and cycle; between beats the data output must hold.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_readdatavalid_o) begin
                exp_t e;
                n_valid++;
                check_eq("valid_when_none_pending", DATA_W'(mem_readdatavalid_o),
                         DATA_W'(exp_q.size() != 0));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("rdata", mem_readdata_o, e.data);
                    check_eq("rvalid_cycle", DATA_W'(cyc), DATA_W'(e.cyc));
                    last_exp = e.data;
                end
            end else begin
                check_eq("rdata_hold", mem_readdata_o, last_exp);
            end
        end
    end

    // Called at a falling edge; returns at the next falling edge after acceptance.
    task automatic do_beat(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [BURST_W-1:0] bc, input logic [DATA_W-1:0] d,
                           input logic [BYTES-1:0] be, output int acc);
        int w = 0;
        mem_read_i       = rd;
        mem_write_i      = wr;
        mem_address_i    = a;
        mem_burstcount_i = bc;
        mem_writedata_i  = d;
        mem_byteenable_i = be;
        while (mem_waitrequest_o !== 1'b0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) check_eq("accept_timeout", DATA_W'(w), '0);
        @(posedge clk);
        #1;
        acc = cyc;
        @(negedge clk);
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
    endtask

    task automatic write_burst(input logic [ADDR_W-1:0] a, input int n, input bit both,
                               output int t0);
        int nb = (n == 0) ? 1 : n;
        int acc;
        for (int k = 0; k < nb; k++) begin
            logic rd;
            logic [ADDR_W-1:0]  ba;
            logic [BURST_W-1:0] bc;
            rd = both && (k == 0 || $urandom_range(0, 1) == 1);
            ba = (k == 0) ? a : ADDR_W'($urandom);
            bc = (k == 0) ? BURST_W'(n) : BURST_W'($urandom);
            do_beat(rd, 1'b1, ba, bc, wbuf[k], bebuf[k], acc);
            if (k == 0) t0 = acc;
            if (n != 0) ref_mem[widx(a, k)] = merge(ref_mem[widx(a, k)], wbuf[k], bebuf[k]);
        end
        $display("WR addr=%h n=%0d rd_also=%0d accepted at cycle %0d", a, n, both, t0);
    endtask

    task automatic read_burst(input logic [ADDR_W-1:0] a, input int n, input bit drain,
                              output int t);
        exp_t e;
        int w = 0;
        do_beat(1'b1, 1'b0, a, BURST_W'(n), '0, '0, t);
        for (int k = 0; k < n; k++) begin
            e.data = ref_mem[widx(a, k)];
            e.cyc  = t + 1 + k;
            exp_q.push_back(e);
        end
        $display("RD addr=%h n=%0d accepted at cycle %0d", a, n, t);
        if (drain) begin
            while (exp_q.size() != 0 && w < n + 50) begin
                @(negedge clk);
                #1;
                w++;
            end
            if (exp_q.size() != 0) check_eq("read_drain_timeout", DATA_W'(exp_q.size()), '0);
        end
    endtask

    // Called right after reset release at a falling edge.
    task automatic lfsr_window(input int cycles);
        logic [15:0] s = 16'hACE1;
        int ones = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
            check_eq("idle_wait_inject", DATA_W'(mem_waitrequest_o), DATA_W'(s[0] & s[1]));
            if (mem_waitrequest_o) ones++;
        end
        check_eq("wait_seen_in_idle", DATA_W'(ones != 0), DATA_W'(1));
        $display("IDLE window %0d cycles, waitrequest high %0d times", cycles, ones);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, acc, v0, w;

        repeat (3) @(negedge clk);
        check_eq("reset_waitrequest", DATA_W'(mem_waitrequest_o), '0);
        check_eq("reset_rvalid", DATA_W'(mem_readdatavalid_o), '0);
        check_eq("reset_rdata", mem_readdata_o, '0);
        rst_n = 1'b1;
        lfsr_window(40);

        for (int i = 0; i < DEPTH; i++) begin
            wbuf[i]  = {$urandom, $urandom, $urandom, $urandom};
            bebuf[i] = '1;
            ref_mem[i] = '0;
        end
        write_burst('0, DEPTH, 1'b0, t);

        // Basic burst write then read back.
        for (int k = 0; k < 4; k++) begin
            wbuf[k]  = DATA_W'(8'hA0 + k);
            bebuf[k] = '1;
        end
        write_burst(ADDR_W'(32'h10), 4, 1'b0, t);
        read_burst(ADDR_W'(32'h10), 4, 1'b1, t);

        // Burst wrapping past the top of memory.
        for (int k = 0; k < 4; k++) wbuf[k] = DATA_W'(8'hB0 + k);
        write_burst(ADDR_W'(32'h3FE), 4, 1'b0, t);
        read_burst(ADDR_W'(32'h3FE), 2, 1'b1, t);
        read_burst(ADDR_W'(32'h000), 2, 1'b1, t);

        // Partial byte-enable overwrite.
        wbuf[0] = '1;
        bebuf[0] = '1;
        write_burst(ADDR_W'(32'h20), 1, 1'b0, t);
        wbuf[0] = '0;
        bebuf[0] = BYTES'(1);
        write_burst(ADDR_W'(32'h20), 1, 1'b0, t);
        read_burst(ADDR_W'(32'h20), 1, 1'b1, t);

        // Zero-length commands: no beats, no memory change.
        v0 = n_valid;
        read_burst(ADDR_W'(32'h10), 0, 1'b1, t);
        repeat (12) @(negedge clk);
        check_eq("bc0_no_valid", DATA_W'(n_valid - v0), '0);
        wbuf[0] = '0;
        bebuf[0] = '1;
        write_burst(ADDR_W'(32'h10), 0, 1'b0, t);
        read_burst(ADDR_W'(32'h10), 1, 1'b1, t);

        // A command issued during an 8-beat read stays stalled until the read ends.
        bebuf[0] = '1;
        wbuf[0] = DATA_W'(32'hC0FFEE);
        read_burst(ADDR_W'(32'h40), 8, 1'b0, t);
        fork
            begin
                for (int i = 0; i <= 8; i++) begin
                    check_eq("wait_during_read", DATA_W'(mem_waitrequest_o), DATA_W'(1));
                    if (i < 8) @(negedge clk);
                end
            end
            begin
                write_burst(ADDR_W'(32'h50), 1, 1'b0, acc);
            end
        join
        check_eq("held_cmd_after_read", DATA_W'(acc >= t + 10), DATA_W'(1));
        read_burst(ADDR_W'(32'h50), 1, 1'b1, t);

        // Reset in the middle of an 8-beat read.
        v0 = n_valid;
        read_burst(ADDR_W'(32'h10), 8, 1'b0, t);
        w = 0;
        while (n_valid < v0 + 3 && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        check_eq("valids_before_reset", DATA_W'(n_valid - v0), DATA_W'(3));
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        last_exp = '0;
        #1;
        check_eq("rst_rvalid_drop", DATA_W'(mem_readdatavalid_o), '0);
        check_eq("rst_waitrequest", DATA_W'(mem_waitrequest_o), '0);
        check_eq("rst_rdata", mem_readdata_o, '0);
        repeat (3) @(negedge clk);
        check_eq("rst_hold_rvalid", DATA_W'(mem_readdatavalid_o), '0);
        rst_n = 1'b1;
        lfsr_window(20);
        read_burst(ADDR_W'(32'h10), 4, 1'b1, t);

        // Random bursts against the reference memory.
        for (int i = 0; i < 1000; i++) begin
            int n;
            logic [ADDR_W-1:0] a;
            n = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 8);
            a = ADDR_W'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 8; k++) begin
                    wbuf[k]  = {$urandom, $urandom, $urandom, $urandom};
                    bebuf[k] = BYTES'($urandom);
                end
                write_burst(a, n, $urandom_range(0, 3) == 0, t);
            end else begin
                read_burst(a, n, 1'b1, t);
            end
        end

        repeat (5) @(negedge clk);
        check_eq("scoreboard_empty", DATA_W'(exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/amm_mem_responder.md
AMM_MEM_RESPONDER -- requirements
Module: amm_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 31, meaning Avalon-MM word-address width.
REQ-002 SHALL have parameter DATA_W, default 128, meaning data width; must be a multiple of 8.
REQ-003 SHALL have parameter BURST_W, default 11, meaning burstcount width.
REQ-004 SHALL have parameter MEM_ADDR_W, default 10, meaning log2 of internal memory depth in words.
REQ-005 SHALL have parameter WAIT_INJECT, default 0, meaning 1 enables pseudo-random waitrequest insertion.
REQ-006 SHALL have port clk_mem_i, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_mem_n_i, input, 1, reset, asynchronous and active-low.
REQ-008 SHALL have port mem_address_i, input, ADDR_W, burst start word address.
REQ-009 SHALL have ports mem_read_i and mem_write_i, input, 1 each, command strobes.
REQ-010 SHALL have port mem_writedata_i, input, DATA_W, write beat data.
REQ-011 SHALL have port mem_burstcount_i, input, BURST_W, beats in burst.
REQ-012 SHALL have port mem_byteenable_i, input, DATA_W/8, per-beat byte lanes.
REQ-013 SHALL have port mem_waitrequest_o, output, 1, stall.
REQ-014 SHALL have port mem_readdatavalid_o, output, 1, read data qualifier.
REQ-015 SHALL have port mem_readdata_o, output, DATA_W, read data.

Function
REQ-016 SHALL implement FSM states IDLE, WRITE, READ; memory of 2**MEM_ADDR_W words, DATA_W wide; only mem_address_i[MEM_ADDR_W-1:0] used.
REQ-017 SHALL treat a beat as accepted when (mem_read_i | mem_write_i) & !mem_waitrequest_o at a clock edge.
REQ-018 SHALL drive mem_waitrequest_o from registers only (no combinational path from inputs): 1 in READ; in IDLE/WRITE equal to inject bit.
REQ-019 SHALL use inject bit = 0 when WAIT_INJECT=0; else lfsr[0] & lfsr[1] of a 16-bit Fibonacci LFSR (taps 16,14,13,11), seed 0xACE1, advancing every cycle.
REQ-020 SHALL, on write accepted in IDLE with burstcount N>=1, latch base, write beat 0 at base with byteenable, go to WRITE if N>1, else stay IDLE.
REQ-021 SHALL, in WRITE, write beat k (k=1..N-1) at (base+k) mod depth, ignore mem_address_i/mem_burstcount_i, return to IDLE after beat N-1.
REQ-022 SHALL leave byte lanes with byteenable=0 unchanged.
REQ-023 SHALL ignore mem_read_i while in WRITE.
REQ-024 SHALL, on read accepted in IDLE at edge T with burstcount N>=1, enter READ and assert mem_readdatavalid_o on cycles T+2..T+N+1 consecutively with data from (base+k) mod depth.
REQ-025 SHALL return to IDLE so mem_waitrequest_o is inject bit in the cycle after the last readdatavalid beat.
REQ-026 SHALL, with read and write both asserted in IDLE, accept as write; read discarded.
REQ-027 SHALL accept burstcount 0 commands with no memory access and no state change.
REQ-028 SHALL hold mem_readdata_o at last value when mem_readdatavalid_o=0.
REQ-029 SHALL make a read return data of all completed prior write beats, including the same address within a later burst.

Reset
REQ-030 SHALL on rst_mem_n_i=0 immediately force: state IDLE, mem_waitrequest_o=0, mem_readdatavalid_o=0, mem_readdata_o=0, LFSR=0xACE1, burst counters 0.
REQ-031 SHALL abort any burst on reset mid-operation; outstanding read beats never issued; memory contents not cleared.

Verification
REQ-032 Write burst N=4 at address 0x10, data 0xA0..0xA3, BE all 1 -> read N=4 at 0x10 returns 0xA0..0xA3 on 4 consecutive valids, first at T+2.
REQ-033 Write at depth-2 with N=4 (MEM_ADDR_W=10, address 0x3FE) -> reading 0x3FE N=2 and 0x000 N=2 returns beats in wrap order.
REQ-034 Write 0xFFFF.. then single write 0x0 with BE=0x0001 -> read returns 0xFFFF..FF00.
REQ-035 Read N=8 issued -> waitrequest=1 from T+1 through T+9, new command held by master, accepted only after.
REQ-036 Reset pulse during read N=8 after 3 valids -> valid drops at once, no further beats, prior written data still readable.
REQ-037 WAIT_INJECT=1, 1000 random write/read bursts vs scoreboard -> zero mismatches, waitrequest seen asserted in IDLE.
